// File: rtl/conv_pim_pkg.sv
// rtl/conv_pim_pkg.sv - shared state type, default widths and done mask for the PIM convolution scheduler
package conv_pim_pkg;

  typedef enum logic [2:0] {IDLE, FILL, FIRE, WAIT, EMIT} state_t;

  localparam int KERNEL_SIZE_DEF = 5;
  localparam int CHANNEL_DEF     = 16;
  localparam int DEPTH_DEF       = 8;
  localparam int OUT_WIDTH_DEF   = 8;
  localparam int WIN_W_DEF       = 16;
  localparam int TIMEOUT_CYC_DEF = 1024;

  localparam logic [CHANNEL_DEF-1:0] ALL_DONE = {CHANNEL_DEF{1'b1}};

endpackage

// File: rtl/pim_done_collect.sv
// rtl/pim_done_collect.sv - sticky OR of per-channel done flags, cleared on each compute kick
module pim_done_collect
  import conv_pim_pkg::*;
#(
  parameter int CHANNEL = CHANNEL_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic [CHANNEL-1:0] done_vec,
  output logic               all_done
);

  logic [CHANNEL-1:0] seen;

  always_ff @(posedge clk) begin
    if (!rst) begin
      seen <= '0;
    end else if (clr) begin
      seen <= '0;
    end else if (en) begin
      seen <= seen | done_vec;
    end
  end

  assign all_done = &seen;

endmodule

// File: rtl/conv_pim_sched.sv
// rtl/conv_pim_sched.sv - PIM convolution tile scheduler; PIM_TIMEOUT_EN adds a WAIT watchdog and the err output
module conv_pim_sched
  import conv_pim_pkg::*;
#(
  parameter int KERNEL_SIZE = KERNEL_SIZE_DEF,
  parameter int CHANNEL     = CHANNEL_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int OUT_WIDTH   = OUT_WIDTH_DEF,
  parameter int WIN_W       = WIN_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int ADDR_W      = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIN_W-1:0]     cfg_windows,
  input  logic [ADDR_W:0]      cfg_banks,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 pim_en,
  output logic                 pim_go,
  output logic [ADDR_W-1:0]    pim_addr,
  input  logic [CHANNEL-1:0]   done_vec,
  input  logic [OUT_WIDTH-1:0] conv_value,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic [ADDR_W-1:0]    out_bank,
  output logic                 busy,
  output logic                 tile_done
`ifdef PIM_TIMEOUT_EN
  ,
  output logic                 err
`endif
);

  localparam int RW = $clog2(KERNEL_SIZE + 1);

  state_t           state, state_nx;
  logic [WIN_W-1:0] windows_q, win_cnt;
  logic [ADDR_W:0]  banks_q, banks_cfg, bank_inc;
  logic [ADDR_W-1:0] bank;
  logic [RW-1:0]    row_cnt, row_target;
  logic             accept, out_fire, last_row, last_bank, last_win;
  logic             all_done, timeout;

  assign accept     = in_ready & in_valid;
  assign out_fire   = out_valid & out_ready;
  // the first window needs the whole kernel, later windows slide by one row
  assign row_target = (win_cnt == '0) ? RW'(KERNEL_SIZE) : RW'(1);
  assign last_row   = (row_cnt + RW'(1)) == row_target;
  assign bank_inc   = {1'b0, bank} + (ADDR_W+1)'(1);
  assign last_bank  = bank_inc >= banks_q;
  assign last_win   = (win_cnt + WIN_W'(1)) == windows_q;
  assign pim_addr   = bank;

  always_comb begin
    banks_cfg = cfg_banks;
    if (cfg_banks == '0) begin
      banks_cfg = (ADDR_W+1)'(1);
    end else if (cfg_banks > (ADDR_W+1)'(DEPTH)) begin
      banks_cfg = (ADDR_W+1)'(DEPTH);
    end
  end

  pim_done_collect #(.CHANNEL(CHANNEL)) u_done (
    .clk      (clk),
    .rst      (rst),
    .clr      (state == FIRE),
    .en       (state == WAIT),
    .done_vec (done_vec),
    .all_done (all_done)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start && cfg_windows != '0) state_nx = FILL;
      FILL: if (accept && last_row) state_nx = FIRE;
      FIRE: state_nx = WAIT;
      WAIT: if (all_done || timeout) state_nx = EMIT;
      EMIT: begin
        if (out_ready) begin
          if (!last_bank)    state_nx = FIRE;
          else if (last_win) state_nx = IDLE;
          else               state_nx = FILL;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == FILL);
    pim_en    = (state == FILL) & in_valid;
    pim_go    = (state == FIRE);
    out_valid = (state == EMIT);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      windows_q <= '0;
      banks_q   <= '0;
      win_cnt   <= '0;
      bank      <= '0;
      row_cnt   <= '0;
      out_data  <= '0;
      out_bank  <= '0;
      tile_done <= 1'b0;
    end else begin
      tile_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_windows == '0) begin
              tile_done <= 1'b1;
            end else begin
              windows_q <= cfg_windows;
              banks_q   <= banks_cfg;
              win_cnt   <= '0;
              bank      <= '0;
              row_cnt   <= '0;
            end
          end
        end
        FILL: if (accept) row_cnt <= row_cnt + RW'(1);
        WAIT: begin
          if (all_done) begin
            out_data <= conv_value;
            out_bank <= bank;
          end else if (timeout) begin
            out_data <= '0;
            out_bank <= bank;
          end
        end
        EMIT: begin
          if (out_fire) begin
            if (!last_bank) begin
              bank <= bank_inc[ADDR_W-1:0];
            end else if (last_win) begin
              tile_done <= 1'b1;
            end else begin
              bank    <= '0;
              win_cnt <= win_cnt + WIN_W'(1);
              row_cnt <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PIM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC);

  logic [TW-1:0] to_cnt;

  // fires on the TIMEOUT_CYC-th WAIT cycle without a full done mask
  assign timeout = (state == WAIT) && !all_done && (to_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      to_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if (state == FIRE) begin
        to_cnt <= '0;
      end else if (state == WAIT) begin
        to_cnt <= to_cnt + TW'(1);
      end
      if (state == IDLE && start) begin
        err <= 1'b0;
      end else if (timeout) begin
        err <= 1'b1;
      end
    end
  end
`else
  logic [31:0] unused_timeout_cyc;

  assign unused_timeout_cyc = TIMEOUT_CYC;
  assign timeout            = 1'b0;
`endif

endmodule

// File: tb/tb_conv_pim_sched.sv
// tb/tb_conv_pim_sched.sv - randomized self-checking bench for conv_pim_sched against a transaction-level model
module tb_conv_pim_sched;
  import conv_pim_pkg::*;

  localparam int KS = 5;
  localparam int NB = 8;

  logic        clk, rst, start, in_valid, in_ready, pim_en, pim_go;
  logic        out_valid, out_ready, busy, tile_done;
  logic [15:0] cfg_windows, done_vec;
  logic [3:0]  cfg_banks;
  logic [2:0]  pim_addr, out_bank;
  logic [7:0]  conv_value, out_data;
`ifdef PIM_TIMEOUT_EN
  logic        err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  conv_pim_sched dut (
    .clk(clk), .rst(rst), .start(start), .cfg_windows(cfg_windows), .cfg_banks(cfg_banks),
    .in_valid(in_valid), .in_ready(in_ready), .pim_en(pim_en), .pim_go(pim_go),
    .pim_addr(pim_addr), .done_vec(done_vec), .conv_value(conv_value),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_bank(out_bank),
    .busy(busy), .tile_done(tile_done)
`ifdef PIM_TIMEOUT_EN
    , .err(err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1);
  end

  // Drives one tile and checks it cycle by cycle against the expected sequence of
  // row loads, kicks, captures and results. Inputs change on the falling edge, outputs are sampled 1 later.
  task automatic run_tile(input int windows, input int banks_raw, input int p_valid, input int p_ready,
                          input int done_mode, input int first_stall, input int conv_fix,
                          input int abort_at, output int n_en, output int n_go);
    int eb, total, n_res, need, phase, stall, cyc, exp_bank, wait_cyc;
    logic [15:0] pend, d;
    logic [7:0]  exp_data;
    logic        exp_en;
    eb = (banks_raw == 0) ? 1 : ((banks_raw > NB) ? NB : banks_raw);
    total = windows * eb;
    n_res = 0; n_en = 0; n_go = 0; phase = 0; need = KS; stall = first_stall;
    cyc = 0; pend = '0; exp_data = '0; wait_cyc = 0;
    @(negedge clk);
    start = 1'b1; cfg_windows = 16'(windows); cfg_banks = 4'(banks_raw);
    in_valid = 1'b0; out_ready = 1'b0; done_vec = 16'($urandom); conv_value = 8'($urandom);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL start_idle_busy got=%b exp=0", busy); end
    while (phase != 4) begin
      if (phase == 1 && n_res == abort_at && wait_cyc == 2) return;
      @(negedge clk);
      cyc++;
      exp_bank    = n_res % eb;
      start       = ($urandom_range(0, 4) == 0);
      cfg_windows = 16'($urandom);
      cfg_banks   = 4'($urandom);
      in_valid    = ($urandom_range(0, 99) < p_valid);
      out_ready   = 1'b0;
      conv_value  = (conv_fix >= 0) ? 8'(conv_fix) : 8'($urandom);
      done_vec    = '0;
      case (phase)
        0: if (need > 0) done_vec = 16'($urandom);
        1: begin
          d = pend & (~pend + 16'd1);
          if (done_mode == 0 && (pend & 16'($urandom)) != '0) d = pend & 16'($urandom);
          if (done_mode == 2) d = pend;
          done_vec = d | (~pend & 16'($urandom));
          pend = pend & ~d;
        end
        2: done_vec = 16'($urandom);
        default: begin
          out_ready = (stall > 0) ? 1'b0 : ($urandom_range(0, 99) < p_ready);
          if (stall > 0) stall--;
          done_vec = 16'($urandom);
        end
      endcase
      #1;
      exp_en = (phase == 0 && need > 0) && in_valid;
      n_cmp++; if (in_ready !== (phase == 0 && need > 0)) begin n_bad++; $display("FAIL in_ready cyc=%0d got=%b phase=%0d need=%0d", cyc, in_ready, phase, need); end
      n_cmp++; if (pim_en !== exp_en) begin n_bad++; $display("FAIL pim_en cyc=%0d got=%b exp=%b", cyc, pim_en, exp_en); end
      n_cmp++; if (pim_go !== (phase == 0 && need == 0)) begin n_bad++; $display("FAIL pim_go cyc=%0d got=%b phase=%0d need=%0d", cyc, pim_go, phase, need); end
      n_cmp++; if (out_valid !== (phase == 3)) begin n_bad++; $display("FAIL out_valid cyc=%0d got=%b phase=%0d", cyc, out_valid, phase); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL busy cyc=%0d got=%b exp=1", cyc, busy); end
      n_cmp++; if (tile_done !== 1'b0) begin n_bad++; $display("FAIL tile_done_early cyc=%0d got=%b exp=0", cyc, tile_done); end
      if (phase >= 1) begin
        n_cmp++; if (pim_addr !== 3'(exp_bank)) begin n_bad++; $display("FAIL pim_addr cyc=%0d got=%0d exp=%0d", cyc, pim_addr, exp_bank); end
      end
      if (phase == 3) begin
        n_cmp++; if (out_data !== exp_data) begin n_bad++; $display("FAIL out_data cyc=%0d got=%h exp=%h", cyc, out_data, exp_data); end
        n_cmp++; if (out_bank !== 3'(exp_bank)) begin n_bad++; $display("FAIL out_bank cyc=%0d got=%0d exp=%0d", cyc, out_bank, exp_bank); end
      end
      case (phase)
        0: begin
          if (need == 0) begin phase = 1; pend = ALL_DONE; wait_cyc = 0; n_go++; end
          else if (exp_en) begin need--; n_en++; end
        end
        1: begin wait_cyc++; if (pend == '0) phase = 2; end
        2: begin exp_data = conv_value; phase = 3; end
        default: begin
          if (out_ready) begin
            n_res++;
            if (n_res == total) phase = 4;
            else begin phase = 0; need = ((n_res % eb) == 0) ? 1 : 0; end
          end
        end
      endcase
      if (cyc > 5000) begin
        n_cmp++; n_bad++; $display("FAIL tile_budget cycles=%0d results=%0d of %0d", cyc, n_res, total);
        return;
      end
      if (n_bad > 40) return;
    end
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; out_ready = 1'b0; done_vec = '0;
    #1;
    n_cmp++; if (tile_done !== 1'b1) begin n_bad++; $display("FAIL tile_done_pulse got=%b exp=1", tile_done); end
    n_cmp++; if ({busy, out_valid, in_ready} !== 3'b000) begin n_bad++; $display("FAIL idle_after_tile got=%b exp=000", {busy, out_valid, in_ready}); end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_cmp++; if (tile_done !== 1'b0) begin n_bad++; $display("FAIL tile_done_width got=%b exp=0", tile_done); end
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    cfg_windows = '0; cfg_banks = '0; done_vec = '0; conv_value = '0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if ({in_ready, pim_en, pim_go, out_valid, busy, tile_done, pim_addr, out_bank, out_data} !== '0) begin
      n_bad++; $display("FAIL reset_outputs got=%h exp=0", {in_ready, pim_en, pim_go, out_valid, busy, tile_done, pim_addr, out_bank, out_data});
    end
`ifdef PIM_TIMEOUT_EN
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", err); end
`endif
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
  endtask

  task automatic test_single;
    int ne, ng;
    run_tile(1, 1, 100, 100, 2, 0, 8'h3C, -1, ne, ng);
    n_cmp++; if (ne !== KS) begin n_bad++; $display("FAIL single_pim_en_count got=%0d exp=%0d", ne, KS); end
    n_cmp++; if (ng !== 1) begin n_bad++; $display("FAIL single_pim_go_count got=%0d exp=1", ng); end
  endtask

  task automatic test_multi_bank;
    int ne, ng;
    run_tile(2, 3, 70, 60, 0, 0, -1, -1, ne, ng);
    n_cmp++; if (ne !== KS + 1) begin n_bad++; $display("FAIL multi_rows got=%0d exp=%0d", ne, KS + 1); end
    n_cmp++; if (ng !== 6) begin n_bad++; $display("FAIL multi_kicks got=%0d exp=6", ng); end
  endtask

  task automatic test_stall;
    int ne, ng;
    run_tile(1, 2, 100, 100, 1, 4, -1, -1, ne, ng);
    n_cmp++; if (ng !== 2) begin n_bad++; $display("FAIL stall_kicks got=%0d exp=2", ng); end
  endtask

  task automatic test_reset_mid_wait;
    int ne, ng;
    run_tile(1, 3, 100, 100, 1, 0, -1, 1, ne, ng);
    @(negedge clk);
    rst = 1'b0; start = 1'b0; in_valid = 1'b1; out_ready = 1'b1; done_vec = '1;
    @(negedge clk);
    #1;
    n_cmp++; if ({in_ready, pim_en, pim_go, out_valid, busy, tile_done, pim_addr, out_bank, out_data} !== '0) begin
      n_bad++; $display("FAIL midwait_reset got=%h exp=0", {in_ready, pim_en, pim_go, out_valid, busy, tile_done, pim_addr, out_bank, out_data});
    end
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; done_vec = '0;
    run_tile(2, 2, 80, 80, 0, 1, -1, -1, ne, ng);
    n_cmp++; if (ng !== 4) begin n_bad++; $display("FAIL post_reset_kicks got=%0d exp=4", ng); end
  endtask

  task automatic test_random;
    int ne, ng, w, b, eb;
    for (int t = 0; t < 8; t++) begin
      w = $urandom_range(1, 3);
      b = $urandom_range(0, NB);
      eb = (b == 0) ? 1 : b;
      run_tile(w, b, $urandom_range(30, 100), $urandom_range(30, 100), 0, $urandom_range(0, 3), -1, -1, ne, ng);
      n_cmp++; if (ng !== w * eb) begin n_bad++; $display("FAIL rand_kicks tile=%0d got=%0d exp=%0d", t, ng, w * eb); end
      n_cmp++; if (ne !== KS + w - 1) begin n_bad++; $display("FAIL rand_rows tile=%0d got=%0d exp=%0d", t, ne, KS + w - 1); end
    end
  endtask

  task automatic test_zero_windows;
    @(negedge clk);
    start = 1'b1; cfg_windows = '0; cfg_banks = 4'd3; in_valid = 1'b1;
    #1;
    n_cmp++; if (tile_done !== 1'b0) begin n_bad++; $display("FAIL zero_win_early got=%b exp=0", tile_done); end
    @(negedge clk);
    start = 1'b0;
    #1;
    n_cmp++; if (tile_done !== 1'b1) begin n_bad++; $display("FAIL zero_win_pulse got=%b exp=1", tile_done); end
    n_cmp++; if ({busy, in_ready, pim_en} !== 3'b000) begin n_bad++; $display("FAIL zero_win_busy got=%b exp=000", {busy, in_ready, pim_en}); end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_cmp++; if ({tile_done, busy} !== 2'b00) begin n_bad++; $display("FAIL zero_win_after got=%b exp=00", {tile_done, busy}); end
  endtask

`ifdef PIM_TIMEOUT_EN
  task automatic test_timeout;
    int k;
    @(negedge clk);
    start = 1'b1; cfg_windows = 16'd1; cfg_banks = 4'd1; in_valid = 1'b1;
    out_ready = 1'b0; done_vec = 16'h7FFF; conv_value = 8'hA5;
    @(negedge clk);
    start = 1'b0;
    #1;
    k = 0;
    while (pim_go !== 1'b1 && k < 20) begin @(negedge clk); #1; k++; end
    n_cmp++; if (pim_go !== 1'b1) begin n_bad++; $display("FAIL to_no_kick got=%b exp=1", pim_go); end
    repeat (1024) @(negedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL to_early got=%b exp=0", out_valid); end
    @(negedge clk);
    #1;
    n_cmp++; if ({out_valid, err, out_data} !== {1'b1, 1'b1, 8'h00}) begin n_bad++; $display("FAIL to_result got=%b/%b/%h exp=1/1/00", out_valid, err, out_data); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    #1;
    n_cmp++; if ({tile_done, err} !== 2'b11) begin n_bad++; $display("FAIL to_done got=%b exp=11", {tile_done, err}); end
    @(negedge clk);
    start = 1'b1; cfg_windows = '0;
    @(negedge clk);
    start = 1'b0;
    #1;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL to_err_clear got=%b exp=0", err); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_multi_bank();
    test_stall();
    test_reset_mid_wait();
    test_random();
    test_zero_windows();
`ifdef PIM_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
